// File: rtl/floo_test_job_sequencer.sv
// Tile-level run controller for DMA test nodes: staggered job release, per-node
// completion latching, watchdog, drain period and cycle-count reporting.
module floo_test_job_sequencer #(
    parameter int unsigned NumNodes      = 2,
    parameter int unsigned CntWidth      = 32,
    parameter int unsigned StaggerCycles = 16,
    parameter int unsigned TimeoutCycles = 1000000,
    parameter int unsigned DrainCycles   = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic [NumNodes-1:0]          done_i,
    output logic [NumNodes-1:0]          start_o,
    output logic                         busy_o,
    output logic                         end_of_sim_o,
    output logic                         timeout_o,
    output logic [NumNodes*CntWidth-1:0] node_cycles_o,
    output logic [CntWidth-1:0]          run_cycles_o
);

    localparam int unsigned IdxW = (NumNodes > 1) ? $clog2(NumNodes) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DRAIN,
        FINISH
    } state_e;

    state_e                state_q;
    logic [NumNodes-1:0]   start_q;
    logic [NumNodes-1:0]   launched_q;
    logic [NumNodes-1:0]   done_q;
    logic [IdxW-1:0]       idx_q;
    logic [CntWidth-1:0]   stag_q;
    logic [CntWidth-1:0]   drain_q;
    logic [CntWidth-1:0]   run_q;
    logic [CntWidth-1:0]   node_q [NumNodes];
    logic                  busy_q;
    logic                  eos_q;
    logic                  to_q;

    logic                  active;
    logic [NumNodes-1:0]   latch_now;
    logic                  all_done_q;
    logic                  all_done_now;
    logic                  watchdog;

    always_comb begin
        active       = (state_q == LAUNCH) || (state_q == WAIT);
        latch_now    = active ? (done_i & launched_q & ~start_q & ~done_q) : '0;
        all_done_q   = &done_q;
        all_done_now = &(done_q | latch_now);
        // A completion latched in the limit cycle suppresses the watchdog; the
        // next WAIT cycle then sees all flags and enters DRAIN normally.
        watchdog     = active && (run_q == CntWidth'(TimeoutCycles - 1)) && !all_done_now;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            start_q    <= '0;
            launched_q <= '0;
            done_q     <= '0;
            idx_q      <= '0;
            stag_q     <= '0;
            drain_q    <= '0;
            run_q      <= '0;
            busy_q     <= 1'b0;
            eos_q      <= 1'b0;
            to_q       <= 1'b0;
            for (int unsigned k = 0; k < NumNodes; k++) begin
                node_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    start_q <= '0;
                    if (en_i) begin
                        state_q    <= LAUNCH;
                        start_q    <= NumNodes'(1);
                        launched_q <= NumNodes'(1);
                        done_q     <= '0;
                        idx_q      <= '0;
                        stag_q     <= '0;
                        run_q      <= '0;
                        busy_q     <= 1'b1;
                        eos_q      <= 1'b0;
                        to_q       <= 1'b0;
                        for (int unsigned k = 0; k < NumNodes; k++) begin
                            node_q[k] <= '0;
                        end
                    end
                end

                LAUNCH, WAIT: begin
                    start_q <= '0;
                    run_q   <= run_q + 1'b1;
                    done_q  <= done_q | latch_now;
                    for (int unsigned k = 0; k < NumNodes; k++) begin
                        if (launched_q[k] && !done_q[k] && !latch_now[k] && (node_q[k] != '1)) begin
                            node_q[k] <= node_q[k] + 1'b1;
                        end
                    end

                    if (watchdog) begin
                        state_q <= FINISH;
                        busy_q  <= 1'b0;
                        eos_q   <= 1'b1;
                        to_q    <= 1'b1;
                        for (int unsigned k = 0; k < NumNodes; k++) begin
                            if (!(done_q[k] || latch_now[k])) begin
                                node_q[k] <= '1;
                            end
                        end
                    end else if (state_q == WAIT) begin
                        if (all_done_q) begin
                            state_q <= DRAIN;
                            drain_q <= '0;
                        end
                    end else if (idx_q == IdxW'(NumNodes - 1)) begin
                        state_q <= WAIT;
                    end else if (stag_q == CntWidth'(StaggerCycles)) begin
                        idx_q      <= idx_q + 1'b1;
                        stag_q     <= '0;
                        start_q    <= NumNodes'(1) << (idx_q + 1'b1);
                        launched_q <= launched_q | (NumNodes'(1) << (idx_q + 1'b1));
                    end else begin
                        stag_q <= stag_q + 1'b1;
                    end
                end

                DRAIN: begin
                    start_q <= '0;
                    if (drain_q == CntWidth'(DrainCycles - 1)) begin
                        state_q <= FINISH;
                        busy_q  <= 1'b0;
                        eos_q   <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end

                FINISH: begin
                    start_q <= '0;
                end

                default: begin
                    state_q <= IDLE;
                    start_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        node_cycles_o = '0;
        for (int unsigned k = 0; k < NumNodes; k++) begin
            node_cycles_o[k*CntWidth +: CntWidth] = node_q[k];
        end
    end

    assign start_o      = start_q;
    assign busy_o       = busy_q;
    assign end_of_sim_o = eos_q;
    assign timeout_o    = to_q;
    assign run_cycles_o = run_q;

endmodule

// File: tb/tb_floo_test_job_sequencer.sv
// Directed self-checking bench for floo_test_job_sequencer; cycle numbers are
// relative to the first cycle after each reset release.
module tb_floo_test_job_sequencer;

    localparam int unsigned NumNodes = 2;
    localparam int unsigned CntWidth = 32;

    logic                         clk;
    logic                         rst;
    logic                         en;
    logic [NumNodes-1:0]          done;
    logic [NumNodes-1:0]          start;
    logic                         busy;
    logic                         eos;
    logic                         tout;
    logic [NumNodes*CntWidth-1:0] node_cycles;
    logic [CntWidth-1:0]          run_cycles;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base     = 0;

    floo_test_job_sequencer #(
        .NumNodes     (NumNodes),
        .CntWidth     (CntWidth),
        .StaggerCycles(3),
        .TimeoutCycles(100),
        .DrainCycles  (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .done_i       (done),
        .start_o      (start),
        .busy_o       (busy),
        .end_of_sim_o (eos),
        .timeout_o    (tout),
        .node_cycles_o(node_cycles),
        .run_cycles_o (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL tb_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int rel);
        while (cyc < base + rel) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        en   = 1'b0;
        done = '0;
        repeat (5) @(posedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;
    endtask

    // {busy, eos, timeout, start}
    function automatic logic [4:0] flags();
        return {busy, eos, tout, start};
    endfunction

    function automatic logic [31:0] nc(input int k);
        return node_cycles[k*CntWidth +: CntWidth];
    endfunction

    initial begin
        // Reset held with en and done asserted
        rst  = 1'b1;
        en   = 1'b1;
        done = 2'b11;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_flags", 64'(flags()), 64'd0);
            chk("reset_counts", {run_cycles, nc(0) | nc(1)}, 64'd0);
            @(posedge clk);
            #1;
        end
        rst  = 1'b0;
        en   = 1'b0;
        done = '0;
        base = cyc;
        goto(3);
        chk("reset_idle_after", 64'(flags()), 64'd0);

        // Normal run with en toggles in WAIT and FINISH
        do_reset();
        goto(10); en = 1'b1;
        goto(11); en = 1'b0;
        chk("norm_start0", 64'(flags()), 64'b10001);
        goto(12); chk("norm_start0_end", 64'(start), 64'd0);
        goto(15); chk("norm_start1", 64'(start), 64'b10);
        goto(16); chk("norm_start1_end", 64'(start), 64'd0);
        goto(20); chk("norm_node0_mid", 64'(nc(0)), 64'd9);
        en = 1'b1;
        goto(21); en = 1'b0;
        goto(22); chk("norm_en_wait_nostart", 64'(start), 64'd0);
        goto(31); done[0] = 1'b1;
        goto(40); done[1] = 1'b1;
        goto(41);
        chk("norm_wait_flags", 64'(flags()), 64'b10000);
        chk("norm_run_wait", 64'(run_cycles), 64'd30);
        goto(45);
        chk("norm_drain_flags", 64'(flags()), 64'b10000);
        chk("norm_run_drain", 64'(run_cycles), 64'd31);
        goto(46);
        chk("norm_finish_flags", 64'(flags()), 64'b01000);
        chk("norm_run", 64'(run_cycles), 64'd31);
        chk("norm_node0", 64'(nc(0)), 64'd20);
        chk("norm_node1", 64'(nc(1)), 64'd25);
        goto(50); en = 1'b1; done = '0;
        goto(53); en = 1'b0;
        chk("norm_en_finish_flags", 64'(flags()), 64'b01000);
        chk("norm_en_finish_counts", {run_cycles, nc(0)}, {32'd31, 32'd20});
        chk("norm_done_drop_node1", 64'(nc(1)), 64'd25);

        // Early done on node 1 ignored until after its start pulse
        do_reset();
        done = 2'b10;
        goto(10); en = 1'b1;
        goto(11); en = 1'b0;
        goto(17); chk("early_node1", 64'(nc(1)), 64'd1);
        goto(20); done[0] = 1'b1;
        goto(25); chk("early_drain_flags", 64'(flags()), 64'b10000);
        goto(26);
        chk("early_finish_flags", 64'(flags()), 64'b01000);
        chk("early_counts", {nc(1), nc(0)}, {32'd1, 32'd9});
        chk("early_run", 64'(run_cycles), 64'd11);

        // Watchdog timeout with node 1 never completing
        do_reset();
        goto(10); en = 1'b1;
        goto(11); en = 1'b0;
        goto(31); done[0] = 1'b1;
        goto(110); chk("to_before_flags", 64'(flags()), 64'b10000);
        goto(111);
        chk("to_flags", 64'(flags()), 64'b01100);
        chk("to_node0", 64'(nc(0)), 64'd20);
        chk("to_node1", 64'(nc(1)), 64'hFFFF_FFFF);
        chk("to_run", 64'(run_cycles), 64'd100);

        // Completion latched in the watchdog limit cycle
        do_reset();
        goto(10); en = 1'b1;
        goto(11); en = 1'b0;
        goto(31); done[0] = 1'b1;
        goto(110); done[1] = 1'b1;
        goto(111); chk("tie_wait_flags", 64'(flags()), 64'b10000);
        goto(115); chk("tie_drain_flags", 64'(flags()), 64'b10000);
        goto(116);
        chk("tie_finish_flags", 64'(flags()), 64'b01000);
        chk("tie_counts", {nc(1), nc(0)}, {32'd95, 32'd20});
        chk("tie_run", 64'(run_cycles), 64'd101);

        // Reset in the middle of WAIT, then a fresh run
        do_reset();
        goto(10); en = 1'b1;
        goto(11); en = 1'b0;
        goto(20); rst = 1'b1;
        goto(21); rst = 1'b0;
        chk("mid_flags", 64'(flags()), 64'd0);
        chk("mid_counts", {run_cycles, nc(0) | nc(1)}, 64'd0);
        goto(25); chk("mid_idle_flags", 64'(flags()), 64'd0);
        goto(30); en = 1'b1;
        goto(31); en = 1'b0;
        chk("mid_restart0", 64'(flags()), 64'b10001);
        goto(35); chk("mid_restart1", 64'(start), 64'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
